// File: rtl/uart_cmd_slave_pkg.sv
// Shared definitions for the UART command slave.
// Holds the UART timing constants, the frame bit indices, the error-code
// encodings, the FSM state enums and the odd-parity helper.
package uart_cmd_slave_pkg;

  localparam int CLK_PER_BIT    = 434;
  localparam int SAMPLE_POINT   = 216;
  localparam int CMD_ADDR_WIDTH = 7;
  localparam int CMD_DATA_WIDTH = 8;
  localparam int RESP_DELAY     = 100;
  localparam int BYTE_TIMEOUT   = 8192;

  localparam int FRAME_BITS = 11;
  localparam int BIT_CNT_W  = $clog2(CLK_PER_BIT);
  localparam int TMO_W      = $clog2(BYTE_TIMEOUT);
  localparam int DLY_W      = $clog2(RESP_DELAY);

  localparam logic [3:0] BIT_START  = 4'd0;
  localparam logic [3:0] BIT_PARITY = 4'd9;
  localparam logic [3:0] BIT_STOP   = 4'd10;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_PARITY  = 2'b01,
    ERR_FRAME   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_code_e;

  typedef enum logic {
    RX_IDLE,
    RX_ACTIVE
  } rx_state_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_RESP_DLY,
    ST_TX
  } cmd_state_e;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [CMD_DATA_WIDTH-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/uart_cmd_slave_rx.sv
// UART byte receiver.
// Synchronises rx, detects the start edge, samples each bit mid-bit and
// checks odd parity and the stop bit.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   rx          asynchronous serial input
//   byte_valid  one-cycle pulse, byte_data holds a good byte
//   byte_data   received byte
//   parity_err  one-cycle pulse, parity bit wrong
//   frame_err   one-cycle pulse, parity good but stop bit low
module uart_rx_byte
  import uart_cmd_slave_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic                      byte_valid,
  output logic [CMD_DATA_WIDTH-1:0] byte_data,
  output logic                      parity_err,
  output logic                      frame_err
);

  logic [2:0]                sync_q, sync_d;
  rx_state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]                idx_q, idx_d;
  logic [CMD_DATA_WIDTH-1:0] data_q, data_d;
  logic                      par_ok_q, par_ok_d;
  logic                      valid_q, valid_d;
  logic                      perr_q, perr_d;
  logic                      ferr_q, ferr_d;
  logic                      rx_s;
  logic                      fall;

  // sync_q[0] is the newest stage; stage 2 is the synchronised line.
  assign rx_s = sync_q[2];
  assign fall = sync_q[2] & ~sync_q[1];

  always_comb begin
    sync_d   = {sync_q[1:0], rx};
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    par_ok_d = par_ok_q;
    valid_d  = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d = RX_ACTIVE;
          cnt_d   = '0;
          idx_d   = BIT_START;
        end
      end
      RX_ACTIVE: begin
        if (cnt_q == BIT_CNT_W'(CLK_PER_BIT - 1)) begin
          cnt_d = '0;
          idx_d = idx_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (cnt_q == BIT_CNT_W'(SAMPLE_POINT)) begin
          if (idx_q == BIT_START) begin
            // Line back high mid start bit: a glitch, not a frame.
            if (rx_s) state_d = RX_IDLE;
          end else if (idx_q == BIT_PARITY) begin
            par_ok_d = (rx_s == odd_parity(data_q));
          end else if (idx_q == BIT_STOP) begin
            // Rearm mid stop bit so the next start edge is not missed.
            state_d = RX_IDLE;
            if (!par_ok_q)  perr_d  = 1'b1;
            else if (!rx_s) ferr_d  = 1'b1;
            else            valid_d = 1'b1;
          end else begin
            data_d = {rx_s, data_q[CMD_DATA_WIDTH-1:1]};
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '1;
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      par_ok_q <= 1'b0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      par_ok_q <= par_ok_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = data_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_cmd_slave.sv
// UART command slave: decodes {rw, addr[6:0]} headers (plus a data byte for
// writes) into register-bus strobes and answers reads with one UART byte.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   rx, tx       serial in from master, serial out to master (idle high)
//   reg_wr_en    one-cycle write strobe, reg_wdata valid with it
//   reg_rd_en    one-cycle read strobe, reg_rdata sampled one cycle later
//   reg_addr     register address, held until the next header
//   busy         command FSM not idle
//   err_pulse    one-cycle error pulse; err_code holds the last error
//
// state        | meaning
// ST_IDLE      | waiting for a header byte
// ST_WAIT_DATA | write header seen, waiting for data byte (timeout running)
// ST_RD_REQ    | read strobe on the bus
// ST_RD_CAP    | capture reg_rdata into the response frame
// ST_RESP_DLY  | line idle before the response start bit
// ST_TX        | shifting out the 11-bit response frame
module uart_cmd_slave
  import uart_cmd_slave_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic                      tx,
  output logic                      reg_wr_en,
  output logic                      reg_rd_en,
  output logic [CMD_ADDR_WIDTH-1:0] reg_addr,
  output logic [CMD_DATA_WIDTH-1:0] reg_wdata,
  input  logic [CMD_DATA_WIDTH-1:0] reg_rdata,
  output logic                      busy,
  output logic                      err_pulse,
  output logic [1:0]                err_code
);

  // The start bit is launched on the same edge that enters ST_TX, so the
  // delay counter covers RESP_DELAY-2 cycles; together with the capture
  // and launch cycles that leaves RESP_DELAY idle clocks after capture.
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(RESP_DELAY - 2);

  logic                      rx_valid;
  logic [CMD_DATA_WIDTH-1:0] rx_byte;
  logic                      rx_perr;
  logic                      rx_ferr;

  cmd_state_e                state_q, state_d;
  logic                      tx_q, tx_d;
  logic                      wr_en_q, wr_en_d;
  logic                      rd_en_q, rd_en_d;
  logic [CMD_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CMD_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      err_pulse_q, err_pulse_d;
  err_code_e                 err_code_q, err_code_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic [DLY_W-1:0]          dly_q, dly_d;
  logic [FRAME_BITS-1:0]     frame_q, frame_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [3:0]                bit_idx_q, bit_idx_d;
  logic [3:0]                idx_nxt;

  uart_rx_byte u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (rx_valid),
    .byte_data  (rx_byte),
    .parity_err (rx_perr),
    .frame_err  (rx_ferr)
  );

  assign idx_nxt = bit_idx_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    tmo_d       = tmo_q;
    dly_d       = dly_q;
    frame_d     = frame_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;

    if (rx_perr) begin
      err_pulse_d = 1'b1;
      err_code_d  = ERR_PARITY;
    end else if (rx_ferr) begin
      err_pulse_d = 1'b1;
      err_code_d  = ERR_FRAME;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          addr_d = rx_byte[CMD_ADDR_WIDTH-1:0];
          if (rx_byte[CMD_DATA_WIDTH-1]) begin
            state_d = ST_WAIT_DATA;
            tmo_d   = TMO_W'(BYTE_TIMEOUT - 1);
          end else begin
            state_d = ST_RD_REQ;
            rd_en_d = 1'b1;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (rx_valid) begin
          wdata_d = rx_byte;
          wr_en_d = 1'b1;
          state_d = ST_IDLE;
        end else if (rx_perr || rx_ferr) begin
          state_d = ST_IDLE;
        end else if (tmo_q == '0) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = ST_IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      ST_RD_REQ: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        frame_d = {1'b1, odd_parity(reg_rdata), reg_rdata, 1'b0};
        dly_d   = DLY_LOAD;
        state_d = ST_RESP_DLY;
      end
      ST_RESP_DLY: begin
        if (dly_q == '0) begin
          state_d   = ST_TX;
          tx_d      = frame_q[0];
          bit_cnt_d = BIT_CNT_W'(CLK_PER_BIT - 1);
          bit_idx_d = BIT_START;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      ST_TX: begin
        if (bit_cnt_q == '0) begin
          if (bit_idx_q == BIT_STOP) begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = idx_nxt;
            tx_d      = frame_q[idx_nxt];
            bit_cnt_d = BIT_CNT_W'(CLK_PER_BIT - 1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tx_q        <= 1'b1;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      tmo_q       <= '0;
      dly_q       <= '0;
      frame_q     <= '1;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      tmo_q       <= tmo_d;
      dly_q       <= dly_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
    end
  end

  assign tx        = tx_q;
  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Self-checking bench for uart_cmd_slave: drives UART frames on rx, models a
// register file on the bus, and decodes the tx response against a reference
// memory of what the bench has written.
module tb_uart_cmd_slave;

  localparam int CPB        = 434;
  localparam int RESP_DLY   = 100;
  localparam int TMO        = 8192;
  localparam int FRAME_CLKS = 11 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       tx;
  logic       reg_wr_en, reg_rd_en;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy, err_pulse;
  logic [1:0] err_code;

  logic [7:0] regs      [0:127];
  logic [7:0] model_mem [0:127];

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int wr_cnt, rd_cnt, err_cnt, tx_low_cnt, busy_cnt, busy_run, last_busy_run;
  int rd_cyc, cap_fall_cyc, cap_n, cap_state;
  logic [6:0] last_wr_addr, last_rd_addr;
  logic [7:0] last_wr_data;
  logic       tx_prev;
  logic       cap [0:FRAME_CLKS-1];

  uart_cmd_slave dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .tx        (tx),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .err_pulse (err_pulse),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  assign reg_rdata = regs[reg_addr];

  // Bus slave plus observation of strobes, errors, busy and the tx line.
  always @(negedge clk) begin
    cyc++;
    if (reg_wr_en) begin
      wr_cnt++;
      last_wr_addr = reg_addr;
      last_wr_data = reg_wdata;
      regs[reg_addr] = reg_wdata;
    end
    if (reg_rd_en) begin
      rd_cnt++;
      last_rd_addr = reg_addr;
      rd_cyc = cyc;
    end
    if (err_pulse) err_cnt++;
    if (tx !== 1'b1) tx_low_cnt++;
    if (busy) begin
      busy_cnt++;
      busy_run++;
    end else begin
      if (busy_run != 0) last_busy_run = busy_run;
      busy_run = 0;
    end
    if (cap_state == 0 && tx_prev === 1'b1 && tx === 1'b0) begin
      cap_state = 1;
      cap_fall_cyc = cyc;
      cap_n = 0;
    end
    if (cap_state == 1) begin
      cap[cap_n] = tx;
      cap_n++;
      if (cap_n == FRAME_CLKS) cap_state = 2;
    end
    tx_prev = tx;
  end

  task clear_mon();
    wr_cnt = 0; rd_cnt = 0; err_cnt = 0; tx_low_cnt = 0; busy_cnt = 0;
    busy_run = 0; last_busy_run = 0; rd_cyc = 0; cap_fall_cyc = 0;
    cap_n = 0; cap_state = 0; tx_prev = tx;
    last_wr_addr = '0; last_rd_addr = '0; last_wr_data = '0;
  endtask

  function automatic logic par_bit(input logic [7:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task send_byte(input logic [7:0] d, input logic bad_par, input logic stop_v);
    logic [10:0] f;
    f = {stop_v, par_bit(d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
    checks++; if ({reg_wr_en, reg_rd_en, busy, err_pulse} !== 4'b0) begin errors++;
      $display("FAIL reset_flags got %b exp 0000", {reg_wr_en, reg_rd_en, busy, err_pulse}); end
    checks++; if ({reg_addr, reg_wdata, err_code} !== 17'h0) begin errors++;
      $display("FAIL reset_regs got %h exp 0", {reg_addr, reg_wdata, err_code}); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task test_read(input logic [6:0] addr);
    int n;
    logic [10:0] exp_f;
    logic [7:0]  d;
    logic        ok;
    d = model_mem[addr];
    exp_f = {1'b1, par_bit(d), d, 1'b0};
    clear_mon();
    send_byte({1'b0, addr}, 1'b0, 1'b1);
    n = 0;
    while (cap_state != 2 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cap_state != 2) begin
      errors++;
      $display("FAIL read_resp_timeout got cap_state %0d exp 2", cap_state);
    end else begin
      checks++; if (rd_cnt != 1) begin errors++; $display("FAIL read_rd_cnt got %0d exp 1", rd_cnt); end
      checks++; if (last_rd_addr !== addr) begin errors++;
        $display("FAIL read_addr got %h exp %h", last_rd_addr, addr); end
      checks++; if (cap_fall_cyc - rd_cyc != RESP_DLY + 1) begin errors++;
        $display("FAIL read_latency got %0d exp %0d", cap_fall_cyc - rd_cyc, RESP_DLY + 1); end
      for (int k = 0; k < 11; k++) begin
        ok = 1'b1;
        for (int j = 0; j < CPB; j++) if (cap[k*CPB + j] !== exp_f[k]) ok = 1'b0;
        checks++; if (!ok) begin errors++;
          $display("FAIL read_bit%0d addr %h got mismatched level exp %b for %0d clk", k, addr, exp_f[k], CPB); end
      end
      checks++; if (wr_cnt != 0) begin errors++; $display("FAIL read_no_wr got %0d exp 0", wr_cnt); end
    end
    repeat (20) @(negedge clk);
    checks++; if ({tx, busy} !== 2'b10) begin errors++;
      $display("FAIL read_end got tx,busy %b exp 10", {tx, busy}); end
  endtask

  task test_write(input logic [6:0] addr, input logic [7:0] data);
    clear_mon();
    send_byte({1'b1, addr}, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    send_byte(data, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    model_mem[addr] = data;
    checks++; if (wr_cnt != 1) begin errors++; $display("FAIL write_cnt got %0d exp 1", wr_cnt); end
    checks++; if (last_wr_addr !== addr) begin errors++;
      $display("FAIL write_addr got %h exp %h", last_wr_addr, addr); end
    checks++; if (last_wr_data !== data) begin errors++;
      $display("FAIL write_data got %h exp %h", last_wr_data, data); end
    checks++; if (reg_addr !== addr) begin errors++;
      $display("FAIL write_addr_held got %h exp %h", reg_addr, addr); end
    checks++; if (rd_cnt != 0 || err_cnt != 0 || tx_low_cnt != 0) begin errors++;
      $display("FAIL write_quiet got rd %0d err %0d txlow %0d exp 0 0 0", rd_cnt, err_cnt, tx_low_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy got %b exp 0", busy); end
  endtask

  task test_rx_error(input logic bad_par, input logic stop_v, input logic [1:0] exp_code);
    clear_mon();
    send_byte(8'h15, bad_par, stop_v);
    repeat (10) @(negedge clk);
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL rxerr_pulses got %0d exp 1", err_cnt); end
    checks++; if (err_code !== exp_code) begin errors++;
      $display("FAIL rxerr_code got %b exp %b", err_code, exp_code); end
    checks++; if (wr_cnt + rd_cnt + busy_cnt != 0) begin errors++;
      $display("FAIL rxerr_quiet got wr %0d rd %0d busy %0d exp 0", wr_cnt, rd_cnt, busy_cnt); end
  endtask

  task test_glitch();
    clear_mon();
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (600) @(negedge clk);
    checks++; if (err_cnt + wr_cnt + rd_cnt + busy_cnt != 0) begin errors++;
      $display("FAIL glitch_quiet got err %0d wr %0d rd %0d busy %0d exp 0", err_cnt, wr_cnt, rd_cnt, busy_cnt); end
    checks++; if (err_code !== 2'b10) begin errors++;
      $display("FAIL glitch_code_held got %b exp 10", err_code); end
  endtask

  task test_timeout();
    int n;
    clear_mon();
    send_byte(8'h95, 1'b0, 1'b1);
    n = 0;
    while (err_cnt == 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checks++; if (last_busy_run != TMO) begin errors++;
      $display("FAIL timeout_busy_len got %0d exp %0d", last_busy_run, TMO); end
    checks++; if (err_code !== 2'b11 || err_cnt != 1) begin errors++;
      $display("FAIL timeout_err got code %b cnt %0d exp 11 1", err_code, err_cnt); end
    checks++; if (wr_cnt + rd_cnt != 0 || busy !== 1'b0) begin errors++;
      $display("FAIL timeout_idle got wr %0d rd %0d busy %b exp 0 0 0", wr_cnt, rd_cnt, busy); end
  endtask

  task test_reset_mid();
    int n;
    logic [6:0] addr;
    addr = 7'($urandom_range(0, 127));
    clear_mon();
    send_byte({1'b0, addr}, 1'b0, 1'b1);
    n = 0;
    while (!(cap_state == 1 && cap_n >= 3 * CPB + 50) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (cap_state != 1) begin errors++;
      $display("FAIL rstmid_no_resp got cap_state %0d exp 1", cap_state); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({tx, busy, reg_rd_en} !== 3'b100) begin errors++;
      $display("FAIL rstmid_state got tx,busy,rd %b exp 100", {tx, busy, reg_rd_en}); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task test_back_to_back();
    logic [6:0] addr;
    logic [7:0] data;
    addr = 7'($urandom_range(0, 127));
    data = 8'($urandom);
    test_write(addr, data);
    test_read(addr);
  endtask

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom);
      regs[i] = v;
      model_mem[i] = v;
    end
    regs[7'h15] = 8'h3C;
    model_mem[7'h15] = 8'h3C;
    clear_mon();

    test_reset();
    test_read(7'h15);
    test_write(7'h15, 8'hA5);
    test_rx_error(1'b1, 1'b1, 2'b01);
    test_rx_error(1'b0, 1'b0, 2'b10);
    test_glitch();
    test_timeout();
    test_read(7'h15);
    test_reset_mid();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
